// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_master_arbiter
//  Description : Two-requester Wishbone arbiter in front of the USB core slave
//                port. m0 is the function controller, m1 the audio stream
//                engine. Ties in IDLE are broken round-robin. A granted
//                requester keeps the bus until it drops cyc. One idle clock
//                separates consecutive grants.
//  Optional    : `define WB_ARB_TIMEOUT_EN compiles in a stall watchdog. After
//                TMO stalled clocks the requester gets a one-clock err pulse,
//                and the arbiter drains until that requester drops cyc.
//  Ports       : clk_i, rst_i (async, active-high)
//                m0_* / m1_*  requester side: cyc/stb/we/addr/data in,
//                             data/ack/err out
//                s_*          USB core side: cyc/stb/we/addr/data out,
//                             data/ack in
//                gnt_o        one-hot grant (bit0 = m0, bit1 = m1)
//  Revision    : 1.0  initial release
// ============================================================================
module wb_master_arbiter #(
    parameter int AW  = 18,
    parameter int TMO = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [31:0]   m0_data_i,
    output logic [31:0]   m0_data_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [31:0]   m1_data_i,
    output logic [31:0]   m1_data_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_addr_o,
    output logic [31:0]   s_data_o,
    input  logic [31:0]   s_data_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
        , ST_DRAIN = 2'd3
`endif
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_gnt;
    logic       r_last;     // requester served last: 0 = m0, 1 = m1
    logic       w_fwd0;     // m0 is connected to the slave this clock
    logic       w_fwd1;     // m1 is connected to the slave this clock

`ifdef WB_ARB_TIMEOUT_EN
    localparam int c_CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

    logic [c_CW-1:0] r_tmo_cnt;
    logic            w_granted;
    logic            w_gnt_stb;
    logic            w_tmo_hit;

    assign w_granted = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    assign w_gnt_stb = ((r_state == ST_GNT0) && m0_stb_i) ||
                       ((r_state == ST_GNT1) && m1_stb_i);
    assign w_tmo_hit = w_granted && (r_tmo_cnt == c_CW'(TMO));

    // Every grant is preceded by IDLE, so clearing outside GNTn covers
    // the clear-on-grant-entry case.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (!w_granted || s_ack_i) begin
            r_tmo_cnt <= '0;
        end else if (w_gnt_stb && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + c_CW'(1);
        end
    end

    assign m0_err_o = w_tmo_hit && (r_state == ST_GNT0);
    assign m1_err_o = w_tmo_hit && (r_state == ST_GNT1);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO != 0);
    assign m0_err_o     = 1'b0;
    assign m1_err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= {w_state_nxt == ST_GNT1, w_state_nxt == ST_GNT0};
            if (r_state == ST_IDLE) begin
                if (w_state_nxt == ST_GNT0) begin
                    r_last <= 1'b0;
                end else if (w_state_nxt == ST_GNT1) begin
                    r_last <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fwd0      = 1'b0;
        w_fwd1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie m0 wins only if m1 was served last.
                if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
                    w_state_nxt = ST_GNT0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
`ifdef WB_ARB_TIMEOUT_EN
                if (w_tmo_hit) begin
                    w_state_nxt = ST_DRAIN;
                end else
`endif
                begin
                    w_fwd0 = 1'b1;
                    if (!m0_cyc_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GNT1: begin
`ifdef WB_ARB_TIMEOUT_EN
                if (w_tmo_hit) begin
                    w_state_nxt = ST_DRAIN;
                end else
`endif
                begin
                    w_fwd1 = 1'b1;
                    if (!m1_cyc_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_DRAIN: begin
                // The errored requester is the one served last.
                if (!(r_last ? m1_cyc_i : m0_cyc_i)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s_cyc_o   = w_fwd0 ? m0_cyc_i  : (w_fwd1 ? m1_cyc_i  : 1'b0);
    assign s_stb_o   = w_fwd0 ? m0_stb_i  : (w_fwd1 ? m1_stb_i  : 1'b0);
    assign s_we_o    = w_fwd0 ? m0_we_i   : (w_fwd1 ? m1_we_i   : 1'b0);
    assign s_addr_o  = w_fwd0 ? m0_addr_i : (w_fwd1 ? m1_addr_i : '0);
    assign s_data_o  = w_fwd0 ? m0_data_i : (w_fwd1 ? m1_data_i : '0);

    assign m0_ack_o  = w_fwd0 && s_ack_i;
    assign m1_ack_o  = w_fwd1 && s_ack_i;
    assign m0_data_o = w_fwd0 ? s_data_i : 32'h0;
    assign m1_data_o = w_fwd1 ? s_data_i : 32'h0;

    assign gnt_o     = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_master_arbiter
//  Description : Self-checking bench for wb_master_arbiter. A bus-ownership
//                reference model predicts grant, routing and responses every
//                clock under directed and random requester/slave traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_master_arbiter;

    localparam int AW  = 18;
    localparam int TMO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_addr_i;
    logic [31:0]   m0_data_i, m0_data_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [31:0]   m1_data_i, m1_data_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [31:0]   s_data_o, s_data_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;

    always #5 clk_i = ~clk_i;

    wb_master_arbiter #(.AW(AW), .TMO(TMO)) u_dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_addr_i (m0_addr_i),
        .m0_data_i (m0_data_i),
        .m0_data_o (m0_data_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_addr_i (m1_addr_i),
        .m1_data_i (m1_data_i),
        .m1_data_o (m1_data_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .gnt_o     (gnt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (0 none, 1 m0, 2 m1) and who won last.
    int   own  = 0;
    int   last = 2;
    bit   auto_drv = 1'b0;
    logic e_ack0 = 1'b0;
    logic e_ack1 = 1'b0;
    int   stall = 0;

    // Random requester state
    bit            cyc[2];
    int            rem[2];
    int            wt[2];
    bit            we_q[2];
    logic [AW-1:0] adr_q[2];
    logic [31:0]   dat_q[2];

    // Ownership rules applied at a clock edge, using the inputs seen at it.
    task automatic model_edge();
        if (own == 0) begin
            if (m0_cyc_i && m1_cyc_i) own = (last == 2) ? 1 : 2;
            else if (m0_cyc_i)        own = 1;
            else if (m1_cyc_i)        own = 2;
            if (own != 0) last = own;
        end else if ((own == 1 && !m0_cyc_i) || (own == 2 && !m1_cyc_i)) begin
            own = 0;
        end
    endtask

    task automatic drive_masters();
        bit ack;
        for (int k = 0; k < 2; k++) begin
            ack = (k == 0) ? e_ack0 : e_ack1;
            if (cyc[k]) begin
                if (ack) begin
                    rem[k]--;
                    if (rem[k] == 0) begin
                        cyc[k] = 1'b0;
                        wt[k]  = $urandom_range(0, 3);
                    end else begin
                        we_q[k] = ($urandom_range(0, 1) == 1);
                        adr_q[k] = AW'($urandom);
                        dat_q[k] = $urandom;
                    end
                end
            end else if (wt[k] > 0) begin
                wt[k]--;
            end else if ($urandom_range(0, 1) == 1) begin
                cyc[k]   = 1'b1;
                rem[k]   = $urandom_range(1, 4);
                we_q[k]  = ($urandom_range(0, 1) == 1);
                adr_q[k] = AW'($urandom);
                dat_q[k] = $urandom;
            end
        end
        m0_cyc_i  = cyc[0];
        m0_stb_i  = cyc[0] && ($urandom_range(0, 3) != 0);
        m0_we_i   = we_q[0];
        m0_addr_i = adr_q[0];
        m0_data_i = dat_q[0];
        m1_cyc_i  = cyc[1];
        m1_stb_i  = cyc[1] && ($urandom_range(0, 3) != 0);
        m1_we_i   = we_q[1];
        m1_addr_i = adr_q[1];
        m1_data_i = dat_q[1];
    endtask

    function automatic bit slave_req();
        return (own == 1 && m0_cyc_i && m0_stb_i) || (own == 2 && m1_cyc_i && m1_stb_i);
    endfunction

    // Slave acks within a few stalled clocks; stray acks appear when unowned.
    task automatic drive_slave();
        if (slave_req()) s_ack_i = (stall >= 3) || ($urandom_range(0, 1) == 1);
        else             s_ack_i = ($urandom_range(0, 3) == 0);
        s_data_i = $urandom;
    endtask

    task automatic check_cycle();
        logic [2:0]    ctl;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [1:0]    g;
        ctl = '0; a = '0; d = '0; g = 2'b00;
        if (own == 1) begin
            ctl = {m0_cyc_i, m0_stb_i, m0_we_i}; a = m0_addr_i; d = m0_data_i; g = 2'b01;
        end else if (own == 2) begin
            ctl = {m1_cyc_i, m1_stb_i, m1_we_i}; a = m1_addr_i; d = m1_data_i; g = 2'b10;
        end
        e_ack0 = (own == 1) && s_ack_i;
        e_ack1 = (own == 2) && s_ack_i;
        chk("gnt",    64'(gnt_o), 64'(g));
        chk("s_ctl",  64'({s_cyc_o, s_stb_o, s_we_o}), 64'(ctl));
        chk("s_addr", 64'(s_addr_o), 64'(a));
        chk("s_data", 64'(s_data_o), 64'(d));
        chk("m0_resp", 64'({m0_ack_o, m0_err_o, m0_data_o}),
            64'({e_ack0, 1'b0, (own == 1) ? s_data_i : 32'h0}));
        chk("m1_resp", 64'({m1_ack_o, m1_err_o, m1_data_o}),
            64'({e_ack1, 1'b0, (own == 2) ? s_data_i : 32'h0}));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        model_edge();
        if (auto_drv) begin
            drive_masters();
            drive_slave();
        end
        @(negedge clk_i);
        check_cycle();
        if (slave_req() && !s_ack_i) stall++;
        else if (s_ack_i)            stall = 0;
    endtask

    task automatic set_m0(input bit c, input bit w, input logic [AW-1:0] a);
        m0_cyc_i = c; m0_stb_i = c; m0_we_i = w; m0_addr_i = a; m0_data_i = 32'h0;
    endtask

    task automatic set_m1(input bit c, input bit w, input logic [AW-1:0] a);
        m1_cyc_i = c; m1_stb_i = c; m1_we_i = w; m1_addr_i = a; m1_data_i = 32'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        set_m0(1'b1, 1'b0, '0);
        set_m1(1'b0, 1'b0, '0);
        s_ack_i  = 1'b1;
        s_data_i = 32'hDEADBEEF;
        for (int k = 0; k < 2; k++) begin
            cyc[k] = 1'b0; rem[k] = 0; wt[k] = 0; we_q[k] = 1'b0; adr_q[k] = '0; dat_q[k] = '0;
        end

        // Reset: request and ack are present but nothing may be forwarded.
        repeat (2) @(negedge clk_i);
        chk("rst_gnt",  64'(gnt_o), 64'(0));
        chk("rst_s",    64'({s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o}), 64'(0));
        chk("rst_resp", 64'({m0_ack_o, m0_err_o, m0_data_o, m1_ack_o, m1_err_o}), 64'(0));
        set_m0(1'b0, 1'b0, '0);
        s_ack_i = 1'b0;
        rst_i   = 1'b0;
        step();

        // Tie sequence: m0, then m1, then m0; m1 read data routing.
        set_m0(1'b1, 1'b0, 18'h00010); set_m1(1'b1, 1'b0, 18'h00020);
        step(); chk("tie1", 64'(gnt_o), 64'(2'b01));
        set_m0(1'b0, 1'b0, '0); set_m1(1'b0, 1'b0, '0);
        step();
        set_m0(1'b1, 1'b0, 18'h00010); set_m1(1'b1, 1'b0, 18'h00020);
        step(); chk("tie2", 64'(gnt_o), 64'(2'b10));
        s_data_i = 32'h12000001; s_ack_i = 1'b1;
        #1;
        chk("rd_m1_data", 64'(m1_data_o), 64'(32'h12000001));
        chk("rd_m0_data", 64'(m0_data_o), 64'(0));
        step();
        set_m0(1'b0, 1'b0, '0); set_m1(1'b0, 1'b0, '0); s_ack_i = 1'b0;
        step();
        set_m0(1'b1, 1'b0, 18'h00010); set_m1(1'b1, 1'b0, 18'h00020);
        step(); chk("tie3", 64'(gnt_o), 64'(2'b01));
        set_m0(1'b0, 1'b0, '0); set_m1(1'b0, 1'b0, '0);
        step(); step();

        // Single m0 write: one-clock grant latency, single ack.
        set_m0(1'b1, 1'b1, 18'h00004);
        #1 chk("lat_pre", 64'(s_cyc_o), 64'(0));
        step(); chk("lat_cyc", 64'(s_cyc_o), 64'(1)); chk("wr_gnt", 64'(gnt_o), 64'(2'b01));
        step();
        s_ack_i = 1'b1;
        #1 chk("wr_ack", 64'(m0_ack_o), 64'(1));
        step();
        set_m0(1'b0, 1'b0, '0); s_ack_i = 1'b0;
        #1 chk("wr_ack_end", 64'(m0_ack_o), 64'(0));
        step(); chk("wr_idle", 64'(gnt_o), 64'(2'b00));

        // m1 burst of 4 reads holds the bus while m0 waits.
        set_m1(1'b1, 1'b0, 18'h0000C);
        step();
        set_m0(1'b1, 1'b1, 18'h00004);
        s_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data_i = $urandom;
            step();
            chk("hold_gnt", 64'(gnt_o), 64'(2'b10));
            chk("hold_m0ack", 64'(m0_ack_o), 64'(0));
        end
        set_m1(1'b0, 1'b0, '0); s_ack_i = 1'b0;
        step(); chk("gap_idle", 64'(gnt_o), 64'(2'b00));
        step(); chk("gap_m0", 64'(gnt_o), 64'(2'b01));
        set_m0(1'b0, 1'b0, '0);
        step(); step();

        // Random traffic against the model.
        auto_drv = 1'b1;
        e_ack0 = 1'b0; e_ack1 = 1'b0; stall = 0;
        repeat (1500) step();

        // Async reset in the middle of an m0 grant.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (own == 1 && m0_cyc_i) found = 1'b1;
        end
        chk("arst_setup", 64'(found), 64'(1));
        auto_drv = 1'b0;
        s_ack_i = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        chk("arst_cyc",  64'({s_cyc_o, s_stb_o}), 64'(0));
        chk("arst_gnt",  64'(gnt_o), 64'(0));
        chk("arst_resp", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'(0));
        own = 0; last = 2; stall = 0;
        for (int k = 0; k < 2; k++) cyc[k] = 1'b0;
        set_m0(1'b0, 1'b0, '0); set_m1(1'b0, 1'b0, '0); s_ack_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        set_m1(1'b1, 1'b0, 18'h0000C);
        step(); chk("post_rst_m1", 64'(gnt_o), 64'(2'b10));
        set_m1(1'b0, 1'b0, '0);
        step(); step();

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: core never acks m0; m1 waits behind the drain.
        begin
            int  n;
            bit  seen;
            n = 0; seen = 1'b0;
            set_m0(1'b1, 1'b1, 18'h00004); set_m1(1'b1, 1'b0, 18'h0000C);
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge clk_i);
                if (m0_err_o) begin
                    seen = 1'b1;
                    chk("tmo_cyc_low", 64'({s_cyc_o, s_stb_o}), 64'(0));
                end else if (s_cyc_o && gnt_o == 2'b01) begin
                    n++;
                end
            end
            chk("tmo_seen",  64'(seen), 64'(1));
            chk("tmo_stall", 64'(n), 64'(TMO));
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_i);
                chk("drain_gnt", 64'(gnt_o), 64'(0));
                chk("drain_s",   64'(s_cyc_o), 64'(0));
                chk("drain_err", 64'({m0_err_o, m1_err_o}), 64'(0));
            end
            set_m0(1'b0, 1'b0, '0);
            @(negedge clk_i); chk("drain_idle", 64'(gnt_o), 64'(0));
            @(negedge clk_i); chk("drain_m1",   64'(gnt_o), 64'(2'b10));
            set_m1(1'b0, 1'b0, '0);
            repeat (2) @(negedge clk_i);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
